// File: rtl/collector_pkg.sv
// Shared definitions for the frame collector: FSM state encoding and counter sizing.
package collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        RELEASE = 2'b10,
        DONE    = 2'b11
    } state_t;

    // $clog2 of 1 is 0; keep every counter at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/collector_counter.sv
// Word index counter: synchronous reset/clear, increments on enable.
module collector_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             EN,
    output logic [WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            COUNT <= '0;
        end else if (EN) begin
            COUNT <= COUNT + 1'b1;
        end
    end

endmodule

// File: rtl/collector.sv
// Collects NUM_WORDS serial words into one frame using a TRIGGER/VALID_IN handshake
// with an upstream serializer; optional per-word timeout.
module collector
    import collector_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOW_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [WIDTH-1:0]           VALUE_IN,
    input  logic                       VALID_IN,
    output logic                       TRIGGER,
    output logic [NUM_WORDS*WIDTH-1:0] VALUES_OUT,
    output logic                       VALID_OUT,
    output logic                       BUSY,
    output logic                       TIMEOUT_ERR
);

    localparam int unsigned IW = $clog2(NUM_WORDS);
    localparam int unsigned WW = cnt_width(TIMEOUT + 1);
    localparam int unsigned RW = cnt_width(LOW_CYCLES + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(LOW_CYCLES - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx;
    logic            idx_clr, idx_inc;
    logic [WW-1:0]   wait_q;
    logic [RW-1:0]   rel_q;
    logic            capture, timeout_hit;

    collector_counter #(.WIDTH(IW)) u_idx (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (idx_clr),
        .EN    (idx_inc),
        .COUNT (idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = REQ;
                    idx_clr = 1'b1;
                end
            end
            REQ: begin
                // A word arriving on the final wait cycle beats the timeout.
                if (VALID_IN) begin
                    capture = 1'b1;
                    state_d = RELEASE;
                end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    timeout_hit = 1'b1;
                    idx_clr     = 1'b1;
                    state_d     = IDLE;
                end
            end
            RELEASE: begin
                if (rel_q == REL_LAST) begin
                    if (idx == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                idx_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_q      <= '0;
            rel_q       <= '0;
            TRIGGER     <= 1'b0;
            VALID_OUT   <= 1'b0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            VALUES_OUT  <= '0;
        end else begin
            wait_q      <= (state_q == REQ && state_d == REQ) ? wait_q + 1'b1 : '0;
            rel_q       <= (state_q == RELEASE && state_d == RELEASE) ? rel_q + 1'b1 : '0;
            TRIGGER     <= (state_q == REQ) && (state_d == REQ);
            VALID_OUT   <= (state_d == DONE);
            BUSY        <= (state_d != IDLE);
            TIMEOUT_ERR <= timeout_hit;
            if (capture) begin
                VALUES_OUT[idx*WIDTH +: WIDTH] <= VALUE_IN;
            end
        end
    end

endmodule

// File: tb/tb_collector.sv
// Directed, table-driven bench for collector (NUM_WORDS=4, WIDTH=8, LOW_CYCLES=2, TIMEOUT=10).
module tb_collector;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [7:0]  VALUE_IN;
    logic        VALID_IN;
    logic        TRIGGER;
    logic [31:0] VALUES_OUT;
    logic        VALID_OUT;
    logic        BUSY;
    logic        TIMEOUT_ERR;

    collector #(
        .NUM_WORDS  (4),
        .WIDTH      (8),
        .LOW_CYCLES (2),
        .TIMEOUT    (10)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .VALUE_IN    (VALUE_IN),
        .VALID_IN    (VALID_IN),
        .TRIGGER     (TRIGGER),
        .VALUES_OUT  (VALUES_OUT),
        .VALID_OUT   (VALID_OUT),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [0:3][7:0] seq;
        logic [0:3][3:0] dly;
        bit              b2b;
        bit              noisy;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs [5];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vo_count = 0;
    int   te_count = 0;

    always @(negedge CLK) begin
        if (VALID_OUT === 1'b1) vo_count++;
        if (TIMEOUT_ERR === 1'b1) te_count++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_trig(input bit noisy, input int exp_low, output bit ok);
        int low = 0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (TRIGGER === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (noisy && low < 2) begin
                VALID_IN = 1'b1;
                VALUE_IN = 8'hFF;
                START    = 1'b1;
            end else begin
                VALID_IN = 1'b0;
                VALUE_IN = 8'h00;
                START    = 1'b0;
            end
            low++;
            step();
        end
        VALID_IN = 1'b0;
        START    = 1'b0;
        if (!ok) chk("trig_wait", {31'b0, TRIGGER}, 32'd1);
        else     chk("trig_low_gap", low, exp_low);
    endtask

    task automatic send_word(input logic [7:0] val, input int dly, input bit noisy,
                             input int exp_low, output bit ok);
        wait_trig(noisy, exp_low, ok);
        if (!ok) return;
        repeat (dly) step();
        VALID_IN = 1'b1;
        VALUE_IN = val;
        step();
        VALID_IN = 1'b0;
        VALUE_IN = 8'h00;
        chk("trig_drop", {31'b0, TRIGGER}, 32'd0);
    endtask

    task automatic begin_frame();
        START = 1'b1;
        step();
        START = 1'b0;
        chk("busy_on_start", {31'b0, BUSY}, 32'd1);
        chk("trig_first_req", {31'b0, TRIGGER}, 32'd0);
    endtask

    // Ends in the DONE cycle (VALID_OUT high) on success.
    task automatic run_frame(input int i);
        bit ok;
        begin_frame();
        for (int k = 0; k < 4; k++) begin
            send_word(vecs[i].seq[k], int'(vecs[i].dly[k]), vecs[i].noisy && k > 0,
                      (k == 0) ? 1 : 3, ok);
            if (!ok) return;
        end
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (VALID_OUT === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk("valid_wait", {31'b0, VALID_OUT}, 32'd1);
        chk("frame", VALUES_OUT, vecs[i].exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trig"}, {31'b0, TRIGGER}, 32'd0);
        chk({tag, "_vals"}, VALUES_OUT, 32'd0);
        chk({tag, "_vout"}, {31'b0, VALID_OUT}, 32'd0);
        chk({tag, "_busy"}, {31'b0, BUSY}, 32'd0);
        chk({tag, "_terr"}, {31'b0, TIMEOUT_ERR}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{{8'h11, 8'h22, 8'h33, 8'h44}, {4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b0, 32'h44332211};
        vecs[1] = '{{8'hA0, 8'hA1, 8'hA2, 8'hA3}, {4'd1, 4'd0, 4'd3, 4'd0}, 1'b1, 1'b0, 32'hA3A2A1A0};
        vecs[2] = '{{8'h5A, 8'h6B, 8'h7C, 8'h8D}, {4'd0, 4'd0, 4'd8, 4'd0}, 1'b0, 1'b0, 32'h8D7C6B5A};
        vecs[3] = '{{8'h04, 8'h03, 8'h02, 8'h01}, {4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b0, 32'h01020304};
        vecs[4] = '{{8'hC1, 8'hC2, 8'hC3, 8'hC4}, {4'd2, 4'd0, 4'd0, 4'd1}, 1'b0, 1'b1, 32'hC4C3C2C1};

        RST = 1'b1; START = 1'b0; VALID_IN = 1'b0; VALUE_IN = 8'h00;
        repeat (3) step();
        chk_all_zero("reset");
        RST = 1'b0;
        step();
        chk("idle_busy", {31'b0, BUSY}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            if (vecs[i].b2b) begin
                START = 1'b1;
                step();
                chk("start_in_done_ignored", {31'b0, BUSY}, 32'd0);
            end else begin
                repeat (2) step();
            end
            run_frame(i);
        end
        step();
        chk("vo_count_a", vo_count, 32'd3);
        chk("te_count_a", te_count, 32'd0);

        // Word 2 never answered: abort on the 10th REQ cycle.
        repeat (2) step();
        begin_frame();
        send_word(8'h55, 0, 1'b0, 1, ok);
        send_word(8'h66, 0, 1'b0, 3, ok);
        wait_trig(1'b0, 3, ok);
        repeat (8) step();
        chk("busy_before_to", {31'b0, BUSY}, 32'd1);
        chk("terr_before_to", {31'b0, TIMEOUT_ERR}, 32'd0);
        step();
        chk("terr_pulse", {31'b0, TIMEOUT_ERR}, 32'd1);
        chk("to_busy", {31'b0, BUSY}, 32'd0);
        chk("to_trig", {31'b0, TRIGGER}, 32'd0);
        chk("to_vout", {31'b0, VALID_OUT}, 32'd0);
        chk("to_partial", VALUES_OUT, 32'h8D7C6655);
        step();
        chk("terr_one_cycle", {31'b0, TIMEOUT_ERR}, 32'd0);
        chk("te_count_b", te_count, 32'd1);
        chk("vo_count_b", vo_count, 32'd3);

        // Reset mid-frame, colliding with START and VALID_IN.
        repeat (2) step();
        begin_frame();
        send_word(8'hAA, 0, 1'b0, 1, ok);
        send_word(8'hBB, 0, 1'b0, 3, ok);
        RST = 1'b1; START = 1'b1; VALID_IN = 1'b1; VALUE_IN = 8'hFF;
        step();
        chk_all_zero("midrst");
        RST = 1'b0; START = 1'b0; VALID_IN = 1'b0; VALUE_IN = 8'h00;
        step();
        chk("post_rst_busy", {31'b0, BUSY}, 32'd0);

        for (int i = 3; i < 5; i++) begin
            repeat (2) step();
            run_frame(i);
        end
        step();
        VALID_IN = 1'b1;
        VALUE_IN = 8'hFF;
        repeat (3) step();
        VALID_IN = 1'b0;
        VALUE_IN = 8'h00;
        step();
        chk("idle_spurious", VALUES_OUT, 32'hC4C3C2C1);
        chk("idle_busy_end", {31'b0, BUSY}, 32'd0);
        chk("vo_count_c", vo_count, 32'd5);
        chk("te_count_c", te_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/collector.md
COLLECTOR -- requirements
Module: collector

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 4, number of words collected per frame (>=2).
REQ-002 SHALL have parameter WIDTH, default 8, bits per word.
REQ-003 SHALL have parameter LOW_CYCLES, default 2, minimum cycles TRIGGER is held low between requests (>=2).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for VALID_IN per word; 0 disables timeout.
REQ-005 SHALL have port CLK, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-007 SHALL have port START, input, 1, single-cycle request to collect one frame.
REQ-008 SHALL have port VALUE_IN, input, WIDTH, serial word from the upstream serializer.
REQ-009 SHALL have port VALID_IN, input, 1, VALUE_IN qualifier.
REQ-010 SHALL have port TRIGGER, output, 1, per-word request level driven to the upstream serializer.
REQ-011 SHALL have port VALUES_OUT, output, NUM_WORDS*WIDTH, assembled frame.
REQ-012 SHALL have port VALID_OUT, output, 1, one-cycle pulse when VALUES_OUT holds a new complete frame.
REQ-013 SHALL have port BUSY, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port TIMEOUT_ERR, output, 1, one-cycle pulse on per-word timeout abort.

Function
REQ-015 SHALL implement states IDLE, REQ, RELEASE, DONE.
REQ-016 IDLE: TRIGGER low; START=1 -> REQ next cycle, word index cleared to 0, wait counter cleared.
REQ-017 REQ: TRIGGER high (registered, rises on the cycle after entering REQ); VALID_IN=1 -> capture VALUE_IN into slot index (bits index*WIDTH +: WIDTH), go to RELEASE.
REQ-018 RELEASE: TRIGGER low for exactly LOW_CYCLES cycles; then index<NUM_WORDS-1 -> increment index, go to REQ; index==NUM_WORDS-1 -> DONE.
REQ-019 DONE: VALID_OUT=1 for that one cycle, index cleared, return to IDLE next cycle.
REQ-020 First received word SHALL occupy slot 0, last word slot NUM_WORDS-1.
REQ-021 VALUES_OUT SHALL update only slot-by-slot at capture and remain stable from DONE until the next capture.
REQ-022 Wait counter SHALL count cycles in REQ; reaching TIMEOUT (TIMEOUT!=0) without VALID_IN -> TIMEOUT_ERR pulse, TRIGGER low, index cleared, to IDLE; no VALID_OUT.
REQ-023 VALID_IN coincident with the timeout cycle SHALL win: word captured, no TIMEOUT_ERR.
REQ-024 START while BUSY=1 SHALL be ignored; no queuing.
REQ-025 VALID_IN outside REQ SHALL be ignored and SHALL NOT alter VALUES_OUT.
REQ-026 START in the same cycle as DONE SHALL be ignored; START in IDLE the cycle after DONE SHALL be accepted.
REQ-027 Index width SHALL be $clog2(NUM_WORDS); wait counter width $clog2(TIMEOUT+1); release counter width $clog2(LOW_CYCLES+1).

Reset
REQ-028 RST=1 at any cycle, including mid-frame, SHALL force IDLE, TRIGGER=0, VALID_OUT=0, BUSY=0, TIMEOUT_ERR=0, all counters 0.
REQ-029 VALUES_OUT SHALL reset to all zeros.
REQ-030 RST SHALL take priority over START and VALID_IN in the same cycle.

Structure
REQ-031 State encodings (IDLE=2'b00, REQ=2'b01, RELEASE=2'b10, DONE=2'b11) SHALL reside in the shared package.
REQ-032 Word index SHALL reuse the existing COUNTER sub-module, reset by RST or clear strobe, enabled by the RELEASE->REQ transition.
REQ-033 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-034 NUM_WORDS=4, WIDTH=8; START, upstream returns 0x11,0x22,0x33,0x44 -> VALUES_OUT=0x44332211, one VALID_OUT pulse, four TRIGGER high periods each followed by >=2 low cycles.
REQ-035 Back-to-back: second START 1 cycle after VALID_OUT, words 0xA0..0xA3 -> second frame 0xA3A2A1A0, VALID_OUT pulses exactly twice total.
REQ-036 TIMEOUT=10, no VALID_IN for word 2 -> TIMEOUT_ERR on 10th REQ cycle, TRIGGER low, BUSY low next cycle, no VALID_OUT.
REQ-037 VALID_IN on exactly the 10th REQ cycle with TIMEOUT=10 -> word captured, no TIMEOUT_ERR, frame completes.
REQ-038 RST asserted after word 1 captured -> all outputs zero next cycle; fresh START then collects 0x01020304 ordering correctly from slot 0.
REQ-039 Spurious VALID_IN with 0xFF in IDLE and RELEASE plus START pulses while BUSY -> VALUES_OUT unchanged, single frame collected.
